video_mode_sequencer: RTL and testbench
=======================================

VIDEO_MODE_SEQUENCER -- requirements
Module: video_mode_sequencer

Interface
REQ-001 SHALL have parameter RESET_MODE, default 4'd0 (VGA_640x480p60), mode code reported after reset.
REQ-002 SHALL have parameter LOCK_STABLE, default 16, consecutive locked cycles required before release.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2_000_000, watchdog limit per wait state.
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports: clk  in  1  system clock (50 MHz domain); reset  in  1  sync active-high reset.
REQ-005 SHALL have these ports:
- mode_req  in  4  requested video mode code.
- mode_req_valid  in  1  request valid.
- mode_req_ready  out  1  request accepted when valid&&ready.
- vs  in  1  frame vsync, already synchronous to clk.
- pll_locked  in  1  PLL lock, already synchronous to clk.
- mgmt_waitrequest  in  1  reconfig bus stall.
- mgmt_readdata  in  32  reconfig read data.
- mgmt_read / mgmt_write  out  1 each  bus strobes.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  write data.
- mode_cur  out  4  mode currently applied.
- blank  out  1  forces video DE low and RGB to 0.
- busy  out  1  sequence in progress.
- mode_ack  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag.

Function
REQ-006 SHALL sequence the FSM IDLE -> WAIT_VS -> WR_MODE -> WR_M -> WR_N -> WR_C0 -> WR_START -> POLL -> WAIT_LOCK -> DONE -> IDLE.
REQ-007 SHALL assert mode_req_ready only in IDLE; a request is latched on valid&&ready.
REQ-008 SHALL, for a request equal to mode_cur, skip the bus sequence: go IDLE -> DONE, then pulse mode_ack the next cycle.
REQ-009 SHALL, in WAIT_VS, detect a vs rising edge (vs && !vs_q), then assert blank from the next cycle until the DONE-to-IDLE transition.
REQ-010 SHALL write, in order: address 0x00 data 1 (polling mode); 0x04 M word; 0x03 N word; 0x05 C0 word; then 0x02 any data (start). M, N and C0 words come from the mode table.
REQ-011 SHALL, on each write, hold mgmt_write, mgmt_address and mgmt_writedata stable while mgmt_waitrequest=1; the transfer completes on the cycle with mgmt_write && !mgmt_waitrequest.
REQ-012 SHALL, in POLL, read address 0x01 repeatedly; data is sampled on mgmt_read && !mgmt_waitrequest; exit when bit0=1.
REQ-013 SHALL, in WAIT_LOCK, count consecutive pll_locked=1 cycles; a 0 restarts the count; exit at LOCK_STABLE.
REQ-014 SHALL, in DONE, update mode_cur to the latched mode, pulse mode_ack for 1 cycle, and clear blank.
REQ-015 SHALL treat unmapped mode codes with the table default entry (1280x1024-class), never as an error.
REQ-016 SHALL assert busy in every state except IDLE; mgmt_read and mgmt_write are never high together.
REQ-017 SHALL clear err on each accepted request.

Reset
REQ-018 SHALL, on reset (any state, including mid-bus-transfer), force IDLE, mode_cur=RESET_MODE, and all other outputs 0.
REQ-019 SHALL assert mode_req_ready on the first cycle after reset deasserts.

Configuration
REQ-020 SHALL, with MODE_SEQ_TIMEOUT_EN defined, run a watchdog counter in WAIT_VS, POLL and WAIT_LOCK, reset on each state entry.
- On reaching TIMEOUT_CYC: set err, clear blank, return to IDLE, leave mode_cur unchanged, no mode_ack.
REQ-021 SHALL, without MODE_SEQ_TIMEOUT_EN, wait indefinitely in those states; err is tied 0 and no watchdog logic is present.

Structure
REQ-022 SHALL place in shared package video_mode_pkg: mode code constants (VGA_640x480p60, MODE_720x480, MODE_1024x768, MODE_1280x1024, FHD_1920x1080p60), reconfig register address constants, and the FSM state enum.
REQ-023 SHALL implement the mode-to-{M,N,C0} lookup as sub-module pll_param_rom (combinational, 4-bit in, 3x32-bit out).

Verification
REQ-024 Reset, then mode_req=3 with valid -> ready=1 at cycle 1; after a vs edge, blank=1; writes occur to 0x00,0x04,0x03,0x05,0x02 in order; mode_ack pulse; mode_cur=3.
REQ-025 mode_req=RESET_MODE right after reset -> mode_ack 2 cycles after acceptance; no mgmt strobes; blank stays 0.
REQ-026 waitrequest held high 5 cycles on the 0x04 write -> address and data stable for all 6 cycles; exactly 5 writes total.
REQ-027 pll_locked toggles low at count 10, then stays high -> release occurs exactly LOCK_STABLE cycles after the re-rise.
REQ-028 With MODE_SEQ_TIMEOUT_EN and TIMEOUT_CYC=100, pll_locked held 0 -> err=1, blank=0, mode_cur unchanged, back in IDLE; next request clears err.
REQ-029 Reset asserted mid-POLL -> next cycle all outputs 0, mode_cur=RESET_MODE.

Source files
------------

// File: rtl/video_mode_pkg.sv
// Shared definitions for the video mode sequencer: mode codes, PLL reconfig
// register map and the sequencer state encoding.
package video_mode_pkg;

  // Video mode codes
  localparam logic [3:0] VGA_640x480p60   = 4'd0;
  localparam logic [3:0] MODE_720x480     = 4'd1;
  localparam logic [3:0] MODE_1024x768    = 4'd2;
  localparam logic [3:0] MODE_1280x1024   = 4'd3;
  localparam logic [3:0] FHD_1920x1080p60 = 4'd4;

  // PLL reconfig management register addresses
  localparam logic [5:0] REG_MODE   = 6'h00;
  localparam logic [5:0] REG_STATUS = 6'h01;
  localparam logic [5:0] REG_START  = 6'h02;
  localparam logic [5:0] REG_N      = 6'h03;
  localparam logic [5:0] REG_M      = 6'h04;
  localparam logic [5:0] REG_C0     = 6'h05;

  // Value written to REG_MODE: polling (not waitrequest) completion mode
  localparam logic [31:0] MODE_POLLING = 32'd1;

  typedef enum logic [3:0] {
    StIdle,
    StWaitVs,
    StWrMode,
    StWrM,
    StWrN,
    StWrC0,
    StWrStart,
    StPoll,
    StWaitLock,
    StDone
  } seq_state_e;

endpackage

// File: rtl/pll_param_rom.sv
// Mode code to PLL counter words {M, N, C0}. Purely combinational.
// Word layout: [17] odd, [16] bypass, [15:8] high count, [7:0] low count.
module pll_param_rom
  import video_mode_pkg::*;
(
  input  logic [3:0]  mode,
  output logic [31:0] m_word,
  output logic [31:0] n_word,
  output logic [31:0] c0_word
);

  // Table lookup; unlisted codes fall back to the 1280x1024-class entry.
  always_comb begin
    m_word  = 32'h0000_1C1B;
    n_word  = 32'h0000_0505;
    c0_word = 32'h0000_0404;
    case (mode)
      VGA_640x480p60: begin
        m_word  = 32'h0000_0F0F;
        n_word  = 32'h0000_0302;
        c0_word = 32'h0002_0F0E;
      end
      MODE_720x480: begin
        m_word  = 32'h0000_1B1A;
        n_word  = 32'h0000_0505;
        c0_word = 32'h0000_1414;
      end
      MODE_1024x768: begin
        m_word  = 32'h0000_0D0D;
        n_word  = 32'h0001_0000;
        c0_word = 32'h0000_0505;
      end
      FHD_1920x1080p60: begin
        m_word  = 32'h0000_1E1E;
        n_word  = 32'h0000_0505;
        c0_word = 32'h0000_0202;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/video_mode_sequencer.sv
// Video mode change sequencer: waits for vsync, blanks video, reprograms the
// pixel PLL over the reconfig management bus, waits for stable lock, then
// reports the new mode. Optional watchdog enabled by defining MODE_SEQ_TIMEOUT_EN.
module video_mode_sequencer
  import video_mode_pkg::*;
#(
  parameter logic [3:0]  RESET_MODE  = VGA_640x480p60,
  parameter int unsigned LOCK_STABLE = 16,
  parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  input  logic        vs,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  input  logic [31:0] mgmt_readdata,
  output logic        mgmt_read,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic [3:0]  mode_cur,
  output logic        blank,
  output logic        busy,
  output logic        mode_ack,
  output logic        err
);

  seq_state_e  state_q, state_d;
  logic [3:0]  mode_lat_q, mode_lat_d;
  logic [3:0]  mode_cur_q, mode_cur_d;
  logic        blank_q, blank_d;
  logic        ack_q, ack_d;
  logic [31:0] lock_cnt_q, lock_cnt_d;
  logic        vs_q;
  logic [31:0] rom_m, rom_n, rom_c0;

`ifdef MODE_SEQ_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  // Only the status done bit is meaningful on reads.
  logic unused_rdata;
  assign unused_rdata = ^mgmt_readdata[31:1];

  pll_param_rom u_rom (
    .mode    (mode_lat_q),
    .m_word  (rom_m),
    .n_word  (rom_n),
    .c0_word (rom_c0)
  );

  // Ready is masked while reset is held so every output reads 0 in reset.
  assign mode_req_ready = (state_q == StIdle) && !reset;
  assign busy           = (state_q != StIdle);
  assign blank          = blank_q;
  assign mode_ack       = ack_q;
  assign mode_cur       = mode_cur_q;

  // Next-state logic for the sequence, lock counter and watchdog.
  always_comb begin
    state_d    = state_q;
    mode_lat_d = mode_lat_q;
    mode_cur_d = mode_cur_q;
    blank_d    = blank_q;
    ack_d      = 1'b0;
    lock_cnt_d = '0;
`ifdef MODE_SEQ_TIMEOUT_EN
    err_d      = err_q;
    wd_d       = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (mode_req_valid && mode_req_ready) begin
          mode_lat_d = mode_req;
`ifdef MODE_SEQ_TIMEOUT_EN
          err_d      = 1'b0;
`endif
          // Re-requesting the active mode needs no PLL traffic.
          state_d    = (mode_req == mode_cur_q) ? StDone : StWaitVs;
        end
      end
      StWaitVs: begin
        if (vs && !vs_q) begin
          blank_d = 1'b1;
          state_d = StWrMode;
        end
      end
      StWrMode:  if (!mgmt_waitrequest) state_d = StWrM;
      StWrM:     if (!mgmt_waitrequest) state_d = StWrN;
      StWrN:     if (!mgmt_waitrequest) state_d = StWrC0;
      StWrC0:    if (!mgmt_waitrequest) state_d = StWrStart;
      StWrStart: if (!mgmt_waitrequest) state_d = StPoll;
      StPoll: begin
        if (!mgmt_waitrequest && mgmt_readdata[0]) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (pll_locked) begin
          if (lock_cnt_q == LOCK_STABLE - 1) begin
            state_d = StDone;
          end else begin
            lock_cnt_d = lock_cnt_q + 32'd1;
          end
        end
      end
      StDone: begin
        mode_cur_d = mode_lat_q;
        ack_d      = 1'b1;
        blank_d    = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef MODE_SEQ_TIMEOUT_EN
    // Counter restarts whenever the state changes; abort without touching mode_cur.
    if ((state_q inside {StWaitVs, StPoll, StWaitLock}) && (state_d == state_q)) begin
      if (wd_q == TIMEOUT_CYC - 1) begin
        state_d    = StIdle;
        blank_d    = 1'b0;
        err_d      = 1'b1;
        lock_cnt_d = '0;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
`endif
  end

  // Bus strobes, address and data decoded from the current state.
  always_comb begin
    mgmt_read      = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;
    unique case (state_q)
      StWrMode: begin
        mgmt_write     = 1'b1;
        mgmt_address   = REG_MODE;
        mgmt_writedata = MODE_POLLING;
      end
      StWrM: begin
        mgmt_write     = 1'b1;
        mgmt_address   = REG_M;
        mgmt_writedata = rom_m;
      end
      StWrN: begin
        mgmt_write     = 1'b1;
        mgmt_address   = REG_N;
        mgmt_writedata = rom_n;
      end
      StWrC0: begin
        mgmt_write     = 1'b1;
        mgmt_address   = REG_C0;
        mgmt_writedata = rom_c0;
      end
      StWrStart: begin
        mgmt_write   = 1'b1;
        mgmt_address = REG_START;
      end
      StPoll: begin
        mgmt_read    = 1'b1;
        mgmt_address = REG_STATUS;
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mode_lat_q <= RESET_MODE;
      mode_cur_q <= RESET_MODE;
      blank_q    <= 1'b0;
      ack_q      <= 1'b0;
      lock_cnt_q <= '0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_lat_q <= mode_lat_d;
      mode_cur_q <= mode_cur_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      lock_cnt_q <= lock_cnt_d;
      vs_q       <= vs;
    end
  end

`ifdef MODE_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Self-checking bench for video_mode_sequencer: randomized bus/vsync/lock
// behaviour checked against a transaction-level model of the mode change.
module tb_video_mode_sequencer;

  localparam logic [3:0]  RESET_MODE  = 4'd0;
  localparam int unsigned LOCK_STABLE = 16;
  localparam int unsigned TIMEOUT_CYC = 100;
  localparam int          BUDGET      = 3000;
  localparam int KNormal    = 0;
  localparam int KGlitch    = 1;
  localparam int KPollReset = 2;
  localparam int KUnlock    = 3;

  logic        clk;
  logic        reset;
  logic [3:0]  mode_req;
  logic        mode_req_valid;
  logic        mode_req_ready;
  logic        vs;
  logic        pll_locked;
  logic        mgmt_waitrequest;
  logic [31:0] mgmt_readdata;
  logic        mgmt_read;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [3:0]  mode_cur;
  logic        blank;
  logic        busy;
  logic        mode_ack;
  logic        err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_mode_sequencer #(
    .RESET_MODE  (RESET_MODE),
    .LOCK_STABLE (LOCK_STABLE),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mode_req         (mode_req),
    .mode_req_valid   (mode_req_valid),
    .mode_req_ready   (mode_req_ready),
    .vs               (vs),
    .pll_locked       (pll_locked),
    .mgmt_waitrequest (mgmt_waitrequest),
    .mgmt_readdata    (mgmt_readdata),
    .mgmt_read        (mgmt_read),
    .mgmt_write       (mgmt_write),
    .mgmt_address     (mgmt_address),
    .mgmt_writedata   (mgmt_writedata),
    .mode_cur         (mode_cur),
    .blank            (blank),
    .busy             (busy),
    .mode_ack         (mode_ack),
    .err              (err)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] model_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {M, N, C0}; unknown codes use the 1280x1024 entry.
  function automatic logic [95:0] ref_words(input logic [3:0] m);
    case (m)
      4'd0:    return {32'h0000_0F0F, 32'h0000_0302, 32'h0002_0F0E};
      4'd1:    return {32'h0000_1B1A, 32'h0000_0505, 32'h0000_1414};
      4'd2:    return {32'h0000_0D0D, 32'h0001_0000, 32'h0000_0505};
      4'd4:    return {32'h0000_1E1E, 32'h0000_0505, 32'h0000_0202};
      default: return {32'h0000_1C1B, 32'h0000_0505, 32'h0000_0404};
    endcase
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    mode_req_valid = 1'b0;
    step();
    step();
    check("rst_strobes", 32'({mgmt_read, mgmt_write, mgmt_address}), 0);
    check("rst_wdata", mgmt_writedata, 0);
    check("rst_flags", 32'({mode_req_ready, busy, blank, mode_ack, err}), 0);
    check("rst_mode", 32'(mode_cur), 32'(RESET_MODE));
    reset = 1'b0;
    #1;
    check("rst_release_ready", 32'(mode_req_ready), 1);
    model_cur = RESET_MODE;
  endtask

  // One mode request from acceptance to completion (or abort), sampled once
  // per cycle. kind selects the lock pattern / abort scenario.
  task automatic run_txn(input logic [3:0] m, input int kind, input int stall_len,
                         input int pre, input int low);
    wr_t         wq[$];
    logic [95:0] w;
    logic [5:0]  prev_a;
    logic [31:0] prev_d;
    int k, j, ack_at, acks, poll_done, last_low, polls_left, stall_left, wr4_cycles, reads;
    int exp_ack;
    bit skip, finished, prev_stall, overlap, stall_bad, blank_bad, strobe_seen, timed_out;

    skip       = (m == model_cur);
    w          = ref_words(m);
    ack_at     = -1;
    acks       = 0;
    poll_done  = -1;
    last_low   = -1;
    polls_left = $urandom_range(0, 3);
    stall_left = stall_len;
    wr4_cycles = 0;
    reads      = 0;
    finished   = 0;
    prev_stall = 0;
    overlap    = 0;
    stall_bad  = 0;
    blank_bad  = 0;
    strobe_seen = 0;
    timed_out  = 0;
    prev_a     = '0;
    prev_d     = '0;

    check("req_ready", 32'(mode_req_ready), 1);
    mode_req         = m;
    mode_req_valid   = 1'b1;
    vs               = 1'b0;
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = '0;
    pll_locked       = 1'b0;
    step();
    mode_req_valid = 1'b0;
    mode_req       = 4'($urandom);
    check("accept_err_clear", 32'(err), 0);
    check("accept_busy", 32'(busy), 1);
    k = 1;

    while (!finished && k < BUDGET) begin
      // Observe this cycle
      if (mgmt_read && mgmt_write) overlap = 1;
      if (mgmt_read || mgmt_write) begin
        strobe_seen = 1;
        if (!blank) blank_bad = 1;
      end
      if (skip && blank) blank_bad = 1;
      if (prev_stall && (!mgmt_write || mgmt_address != prev_a || mgmt_writedata != prev_d))
        stall_bad = 1;
      if (mgmt_write && mgmt_address == 6'h04) wr4_cycles++;
      if (mode_ack) begin
        acks++;
        if (ack_at < 0) ack_at = k;
      end
      if (ack_at >= 0 && k > ack_at) finished = 1;
      if (kind == KUnlock && err) begin
        timed_out = 1;
        finished  = 1;
      end
      if (kind == KPollReset && reads >= 3) finished = 1;

      // Drive inputs for the next edge
      if (!finished) begin
        vs               = ($urandom_range(0, 3) == 0);
        mgmt_waitrequest = ($urandom_range(0, 2) == 0);
        if (mgmt_write && mgmt_address == 6'h04 && stall_len > 0) begin
          mgmt_waitrequest = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        prev_stall = mgmt_write && mgmt_waitrequest;
        prev_a     = mgmt_address;
        prev_d     = mgmt_writedata;
        if (mgmt_write && !mgmt_waitrequest) wq.push_back(wr_t'{mgmt_address, mgmt_writedata});
        mgmt_readdata = $urandom;
        if (mgmt_read && !mgmt_waitrequest) begin
          reads++;
          if (kind != KPollReset && polls_left == 0) begin
            mgmt_readdata[0] = 1'b1;
            poll_done        = k;
          end else begin
            mgmt_readdata[0] = 1'b0;
            if (polls_left > 0) polls_left--;
          end
        end
        if (poll_done >= 0 && k > poll_done) begin
          j = k - poll_done - 1;
          if (kind == KGlitch)      pll_locked = (j < pre) || (j >= pre + low);
          else if (kind == KUnlock) pll_locked = 1'b0;
          else                      pll_locked = 1'b1;
          if (!pll_locked) last_low = k;
        end else begin
          pll_locked = 1'($urandom_range(0, 1));
        end
        step();
        k++;
      end
    end

    check("txn_finished", 32'(finished), 1);
    check("rw_overlap", 32'(overlap), 0);

    if (kind == KPollReset) begin
      reset = 1'b1;
      step();
      check("poll_rst_strobes", 32'({mgmt_read, mgmt_write, mgmt_address}), 0);
      check("poll_rst_wdata", mgmt_writedata, 0);
      check("poll_rst_flags", 32'({mode_req_ready, busy, blank, mode_ack, err}), 0);
      check("poll_rst_mode", 32'(mode_cur), 32'(RESET_MODE));
      reset = 1'b0;
      #1;
      check("poll_rst_ready", 32'(mode_req_ready), 1);
      model_cur = RESET_MODE;
      return;
    end

    if (kind == KUnlock) begin
      check("to_seen", 32'(timed_out), 1);
      check("to_blank", 32'(blank), 0);
      check("to_busy", 32'(busy), 0);
      check("to_mode_kept", 32'(mode_cur), 32'(model_cur));
      check("to_no_ack", acks, 0);
      check("to_ready", 32'(mode_req_ready), 1);
      return;
    end

    exp_ack = ((last_low >= 0) ? last_low + 1 : poll_done + 1) + LOCK_STABLE + 1;
    check("ack_count", acks, 1);
    check("mode_cur", 32'(mode_cur), 32'(m));
    check("idle_busy", 32'(busy), 0);
    check("idle_blank", 32'(blank), 0);
    check("idle_ready", 32'(mode_req_ready), 1);
    check("blank_window", 32'(blank_bad), 0);
    if (skip) begin
      check("skip_ack_lat", ack_at, 2);
      check("skip_strobes", 32'(strobe_seen), 0);
      check("skip_wr_count", 32'(wq.size()), 0);
    end else begin
      check("wr_count", 32'(wq.size()), 5);
      check("ack_lat", ack_at, exp_ack);
      check("stall_stable", 32'(stall_bad), 0);
      if (stall_len > 0) check("stall_cycles", wr4_cycles, stall_len + 1);
      if (wq.size() == 5) begin
        check("wr0_addr", 32'(wq[0].addr), 32'h00);
        check("wr1_addr", 32'(wq[1].addr), 32'h04);
        check("wr2_addr", 32'(wq[2].addr), 32'h03);
        check("wr3_addr", 32'(wq[3].addr), 32'h05);
        check("wr4_addr", 32'(wq[4].addr), 32'h02);
        check("wr_mode_data", wq[0].data, 1);
        check("wr_m_data", wq[1].data, w[95:64]);
        check("wr_n_data", wq[2].data, w[63:32]);
        check("wr_c0_data", wq[3].data, w[31:0]);
      end
    end
    model_cur = m;
  endtask

  initial begin
    logic [3:0] m;
    reset            = 1'b1;
    mode_req         = '0;
    mode_req_valid   = 1'b0;
    vs               = 1'b0;
    pll_locked       = 1'b0;
    mgmt_waitrequest = 1'b0;
    mgmt_readdata    = '0;
    model_cur        = RESET_MODE;

    do_reset();
    run_txn(RESET_MODE, KNormal, 0, 0, 0);
    run_txn(4'd3, KNormal, 0, 0, 0);
    run_txn(4'd3, KNormal, 0, 0, 0);
    run_txn(4'd2, KNormal, 5, 0, 0);
    run_txn(4'd4, KGlitch, 0, 10, 1);
    run_txn(4'd11, KNormal, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      m = 4'($urandom_range(0, 15));
      run_txn(m, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1) * $urandom_range(1, 6)),
              int'($urandom_range(0, 14)), int'($urandom_range(1, 3)));
    end

    m = (model_cur == 4'd1) ? 4'd2 : 4'd1;
    run_txn(m, KNormal, 0, 0, 0);
    m = (model_cur == 4'd4) ? 4'd3 : 4'd4;
    run_txn(m, KPollReset, 0, 0, 0);

`ifdef MODE_SEQ_TIMEOUT_EN
    run_txn(4'd2, KNormal, 0, 0, 0);
    run_txn(4'd4, KUnlock, 0, 0, 0);
    run_txn(4'd1, KNormal, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
